// File: rtl/servo_pkg.sv
// Shared widths, default servo timing constants and the command clamp used by
// both the PWM generator and the upstream control logic.
package servo_pkg;

  typedef logic [15:0] width_t;

  localparam int unsigned CLK_HZ     = 32'd50_000_000;
  localparam int unsigned FRAME_US   = 32'd20000;
  localparam int unsigned PW_MIN     = 32'd1000;
  localparam int unsigned PW_MAX     = 32'd2000;
  localparam int unsigned PW_NEUTRAL = 32'd1500;
  localparam int unsigned SLEW_US    = 32'd50;

  typedef struct packed {
    width_t width;
    logic   clamped;
  } clamp_res_t;

  // A zero command is an "off" request only where zero_is_off is set; off is not a clamp.
  function automatic clamp_res_t clamp_width(input width_t cmd, input logic zero_is_off,
                                             input width_t lo, input width_t hi);
    clamp_res_t res;
    res.width   = cmd;
    res.clamped = 1'b0;
    if (zero_is_off && (cmd == 16'd0)) begin
      res.width   = 16'd0;
      res.clamped = 1'b0;
    end else if (cmd < lo) begin
      res.width   = lo;
      res.clamped = 1'b1;
    end else if (cmd > hi) begin
      res.width   = hi;
      res.clamped = 1'b1;
    end else begin
      res.width   = cmd;
      res.clamped = 1'b0;
    end
    return res;
  endfunction

endpackage

// File: rtl/pwm_channel.sv
// One PWM output channel: frame-latched applied width with optional slew
// limiting, and a registered pin that is high while us_cnt < applied width.
module pwm_channel
  import servo_pkg::*;
#(
  parameter bit          SLEW_EN   = 1'b0,
  parameter int unsigned SLEW_STEP = 32'd50,
  parameter int unsigned FLOOR_W   = 32'd1000,
  parameter int unsigned SAFE_W    = 32'd0
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   load_i,
  input  logic   safe_i,
  input  logic   pin_en_i,
  input  width_t target_i,
  input  width_t us_cnt_i,
  output width_t applied_o,
  output logic   pin_o
);

  localparam width_t STEP_W  = width_t'(SLEW_STEP);
  localparam width_t FLOOR_V = width_t'(FLOOR_W);
  localparam width_t SAFE_V  = width_t'(SAFE_W);

  width_t applied_q, applied_d;
  logic   pin_q, pin_d;
  logic   up_s;
  width_t diff_s, step_s, slew_s;

  // Next applied width (slewed or direct) and next pin level.
  always_comb begin
    up_s   = (target_i > applied_q);
    diff_s = up_s ? (target_i - applied_q) : (applied_q - target_i);
    step_s = (diff_s < STEP_W) ? diff_s : STEP_W;

    // An off target bypasses the slew so the drive can always be cut at once.
    if (target_i == 16'd0) begin
      slew_s = 16'd0;
    end else if (applied_q == 16'd0) begin
      slew_s = FLOOR_V;
    end else if (up_s) begin
      slew_s = applied_q + step_s;
    end else begin
      slew_s = applied_q - step_s;
    end

    applied_d = applied_q;
    if (!load_i) begin
      applied_d = applied_q;
    end else if (safe_i) begin
      applied_d = SAFE_V;
    end else if (SLEW_EN) begin
      applied_d = slew_s;
    end else begin
      applied_d = target_i;
    end

    pin_d = pin_en_i && (us_cnt_i < applied_q);
  end

  // Applied width and pin registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      applied_q <= SAFE_V;
      pin_q     <= 1'b0;
    end else begin
      applied_q <= applied_d;
      pin_q     <= pin_d;
    end
  end

  assign applied_o = applied_q;
  assign pin_o     = pin_q;

endmodule

// File: rtl/servo_pwm_gen.sv
// Two-channel 50 Hz RC PWM generator: 1 us prescaler, frame counter, frame-start
// command sampling/clamping, slew-limited ESC channel and direct servo channel.
module servo_pwm_gen #(
  parameter int unsigned CLK_HZ     = servo_pkg::CLK_HZ,
  parameter int unsigned TICK_DIV   = CLK_HZ / 32'd1_000_000,
  parameter int unsigned FRAME_US   = servo_pkg::FRAME_US,
  parameter int unsigned PW_MIN     = servo_pkg::PW_MIN,
  parameter int unsigned PW_MAX     = servo_pkg::PW_MAX,
  parameter int unsigned PW_NEUTRAL = servo_pkg::PW_NEUTRAL,
  parameter int unsigned SLEW_US    = servo_pkg::SLEW_US
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  servo_pkg::width_t speed_control,
  input  servo_pkg::width_t angle_control,
  output logic              pwm_speed,
  output logic              pwm_angle,
  output logic              frame_strobe,
  output servo_pkg::width_t speed_applied,
  output servo_pkg::width_t angle_applied,
  output logic              clamped
);
  import servo_pkg::*;

  localparam int unsigned       TICK_W     = (TICK_DIV > 32'd1) ? $clog2(TICK_DIV) : 1;
  localparam logic [TICK_W-1:0] TICK_LAST  = TICK_W'(TICK_DIV - 32'd1);
  localparam width_t            FRAME_LAST = width_t'(FRAME_US - 32'd1);
  localparam width_t            MIN_W      = width_t'(PW_MIN);
  localparam width_t            MAX_W      = width_t'(PW_MAX);

  logic [TICK_W-1:0] tick_cnt_q, tick_cnt_d;
  width_t            us_cnt_q, us_cnt_d;
  logic              run_q, run_d;
  logic              frame_strobe_q, frame_strobe_d;
  logic              clamped_q, clamped_d;
  logic              tick_s, frame_start_s, safe_s, pin_en_s;
  clamp_res_t        spd_res_s, ang_res_s;

  // Timebase, frame-start detection, run gating and clamp status.
  always_comb begin
    tick_s        = (tick_cnt_q == TICK_LAST);
    frame_start_s = tick_s && (us_cnt_q == FRAME_LAST);
    spd_res_s     = clamp_width(speed_control, 1'b1, MIN_W, MAX_W);
    ang_res_s     = clamp_width(angle_control, 1'b0, MIN_W, MAX_W);
    safe_s        = !enable;

    tick_cnt_d = tick_s ? '0 : (tick_cnt_q + TICK_W'(32'd1));

    us_cnt_d = us_cnt_q;
    if (!tick_s) begin
      us_cnt_d = us_cnt_q;
    end else if (us_cnt_q == FRAME_LAST) begin
      us_cnt_d = 16'd0;
    end else begin
      us_cnt_d = us_cnt_q + 16'd1;
    end

    // Pins stay quiet after a disable until a full frame can be produced.
    run_d = run_q;
    if (!enable) begin
      run_d = 1'b0;
    end else if (frame_start_s) begin
      run_d = 1'b1;
    end else begin
      run_d = run_q;
    end

    clamped_d = clamped_q;
    if (!frame_start_s) begin
      clamped_d = clamped_q;
    end else if (!enable) begin
      clamped_d = 1'b0;
    end else begin
      clamped_d = spd_res_s.clamped | ang_res_s.clamped;
    end

    frame_strobe_d = frame_start_s;
    pin_en_s       = enable && run_q;
  end

  // Timebase and status registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_cnt_q     <= '0;
      us_cnt_q       <= 16'd0;
      run_q          <= 1'b0;
      frame_strobe_q <= 1'b0;
      clamped_q      <= 1'b0;
    end else begin
      tick_cnt_q     <= tick_cnt_d;
      us_cnt_q       <= us_cnt_d;
      run_q          <= run_d;
      frame_strobe_q <= frame_strobe_d;
      clamped_q      <= clamped_d;
    end
  end

  pwm_channel #(
    .SLEW_EN  (1'b1),
    .SLEW_STEP(SLEW_US),
    .FLOOR_W  (PW_MIN),
    .SAFE_W   (32'd0)
  ) u_speed (
    .clk      (clk),
    .rst_n    (rst_n),
    .load_i   (frame_start_s),
    .safe_i   (safe_s),
    .pin_en_i (pin_en_s),
    .target_i (spd_res_s.width),
    .us_cnt_i (us_cnt_q),
    .applied_o(speed_applied),
    .pin_o    (pwm_speed)
  );

  pwm_channel #(
    .SLEW_EN  (1'b0),
    .SLEW_STEP(SLEW_US),
    .FLOOR_W  (PW_MIN),
    .SAFE_W   (PW_NEUTRAL)
  ) u_angle (
    .clk      (clk),
    .rst_n    (rst_n),
    .load_i   (frame_start_s),
    .safe_i   (safe_s),
    .pin_en_i (pin_en_s),
    .target_i (ang_res_s.width),
    .us_cnt_i (us_cnt_q),
    .applied_o(angle_applied),
    .pin_o    (pwm_angle)
  );

  assign frame_strobe = frame_strobe_q;
  assign clamped      = clamped_q;

endmodule

// File: tb/tb_servo_pwm_gen.sv
// Self-checking bench for servo_pwm_gen on a scaled-down timebase (2 clk/us,
// 40 us frame, 10..20 us legal widths, slew 2 us/frame).
module tb_servo_pwm_gen;

  localparam int TD   = 2;
  localparam int FR   = 40;
  localparam int F    = TD * FR;
  localparam int PMIN = 10;
  localparam int PMAX = 20;
  localparam int PNEU = 15;
  localparam int SLEW = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        enable = 1'b0;
  logic [15:0] speed_control = 16'd0;
  logic [15:0] angle_control = 16'd0;
  logic        pwm_speed, pwm_angle, frame_strobe, clamped;
  logic [15:0] speed_applied, angle_applied;

  int checks = 0;
  int errors = 0;

  servo_pwm_gen #(
    .CLK_HZ    (2_000_000),
    .TICK_DIV  (TD),
    .FRAME_US  (FR),
    .PW_MIN    (PMIN),
    .PW_MAX    (PMAX),
    .PW_NEUTRAL(PNEU),
    .SLEW_US   (SLEW)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .enable       (enable),
    .speed_control(speed_control),
    .angle_control(angle_control),
    .pwm_speed    (pwm_speed),
    .pwm_angle    (pwm_angle),
    .frame_strobe (frame_strobe),
    .speed_applied(speed_applied),
    .angle_applied(angle_applied),
    .clamped      (clamped)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  function automatic int clamp_val(input int c, input bit is_speed);
    if (is_speed && c == 0) return 0;
    if (c < PMIN) return PMIN;
    if (c > PMAX) return PMAX;
    return c;
  endfunction

  function automatic bit clamp_hit(input int c, input bit is_speed);
    if (is_speed && c == 0) return 1'b0;
    return (c < PMIN) || (c > PMAX);
  endfunction

  function automatic int slew_to(input int a, input int t);
    if (t == 0) return 0;
    if (a == 0) return PMIN;
    if (t > a) return (t - a > SLEW) ? a + SLEW : t;
    return (a - t > SLEW) ? a - SLEW : t;
  endfunction

  int m_cnt, m_q, m_spd, m_ang;
  bit m_ok, m_strobe, m_clamp, m_ps, m_pa;
  bit m_valid = 1'b0;

  // m_cnt = clock edges since reset release; m_q = edges since the last frame start.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_cnt = 0; m_q = 0; m_ok = 1'b0; m_strobe = 1'b0; m_clamp = 1'b0;
      m_spd = 0; m_ang = PNEU; m_ps = 1'b0; m_pa = 1'b0; m_valid = 1'b1;
    end else begin
      m_cnt++;
      m_strobe = (m_cnt % F == 0);
      if (m_strobe) begin
        m_q  = 0;
        m_ok = enable;
        if (enable) begin
          m_spd   = slew_to(m_spd, clamp_val(int'(speed_control), 1'b1));
          m_ang   = clamp_val(int'(angle_control), 1'b0);
          m_clamp = clamp_hit(int'(speed_control), 1'b1) | clamp_hit(int'(angle_control), 1'b0);
        end else begin
          m_spd = 0; m_ang = PNEU; m_clamp = 1'b0;
        end
      end else begin
        m_q++;
        m_ok = m_ok && enable;
      end
      m_ps = m_ok && (m_q >= 1) && (m_q <= m_spd * TD);
      m_pa = m_ok && (m_q >= 1) && (m_q <= m_ang * TD);
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (m_valid) begin
      chk("pwm_speed", pwm_speed, m_ps);
      chk("pwm_angle", pwm_angle, m_pa);
      chk("frame_strobe", frame_strobe, m_strobe);
      chk("speed_applied", speed_applied, m_spd);
      chk("angle_applied", angle_applied, m_ang);
      chk("clamped", clamped, m_clamp);
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic wait_strobe(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!frame_strobe && n < 3 * F);
    if (!frame_strobe) chk("strobe_timeout", 0, 1);
  endtask

  task automatic count_frame(output int hs, output int ha);
    hs = 0; ha = 0;
    for (int i = 0; i < F; i++) begin
      hs += int'(pwm_speed);
      ha += int'(pwm_angle);
      @(negedge clk);
    end
  endtask

  int n, hs, ha;
  int ramp_exp[5]   = '{12, 14, 16, 18, 20};
  int tbl_spd[5]    = '{20, 20, 20, 25, 20};
  int tbl_ang[5]    = '{26, 4, 12, 12, 0};
  int tbl_ang_x[5]  = '{20, 10, 12, 12, 10};
  int tbl_clp_x[5]  = '{1, 1, 0, 1, 1};
  int ramp17_exp[5] = '{10, 12, 14, 16, 17};

  initial begin
    #1 rst_n = 1'b0;
    enable = 1'b1; angle_control = 16'd15; speed_control = 16'd20;
    repeat (3) @(negedge clk);
    chk("reset_pwm_speed", pwm_speed, 0);
    chk("reset_speed_applied", speed_applied, 0);
    chk("reset_angle_applied", angle_applied, PNEU);
    rst_n = 1'b1;

    // First frame and throttle ramp.
    wait_strobe(n);
    chk("first_strobe_latency", n, 80);
    chk("frame1_speed", speed_applied, 10);
    chk("frame1_angle", angle_applied, 15);
    chk("frame1_clamped", clamped, 0);
    count_frame(hs, ha);
    chk("frame1_speed_high", hs, 20);
    chk("frame1_angle_high", ha, 30);
    chk("frame2_speed", speed_applied, 12);
    for (int i = 1; i < 5; i++) begin
      wait_strobe(n);
      chk("ramp_speed", speed_applied, ramp_exp[i]);
    end
    wait_strobe(n);
    chk("ramp_hold", speed_applied, 20);

    // Clamping table.
    for (int i = 0; i < 5; i++) begin
      speed_control = 16'(tbl_spd[i]);
      angle_control = 16'(tbl_ang[i]);
      wait_strobe(n);
      chk("clamp_angle", angle_applied, tbl_ang_x[i]);
      chk("clamp_flag", clamped, tbl_clp_x[i]);
      chk("clamp_speed", speed_applied, 20);
    end

    // Off request cuts throttle with no ramp.
    speed_control = 16'd0; angle_control = 16'd15;
    wait_strobe(n);
    chk("off_speed", speed_applied, 0);
    count_frame(hs, ha);
    chk("off_speed_high", hs, 0);
    chk("off_angle_high", ha, 30);

    // Ramp to a target that is not a multiple of the slew step.
    speed_control = 16'd17;
    for (int i = 0; i < 5; i++) begin
      wait_strobe(n);
      chk("ramp17_speed", speed_applied, ramp17_exp[i]);
    end

    // Mid-frame command change is deferred to the next frame.
    hs = 0; ha = 0;
    for (int i = 0; i < F; i++) begin
      if (i == 14) angle_control = 16'd10;
      hs += int'(pwm_speed);
      ha += int'(pwm_angle);
      @(negedge clk);
    end
    chk("midframe_old_angle_high", ha, 30);
    chk("midframe_speed_high", hs, 34);
    count_frame(hs, ha);
    chk("midframe_new_angle_high", ha, 20);
    angle_control = 16'd15;

    // Disable mid-pulse, then re-enable.
    wait_strobe(n);
    repeat (5) @(negedge clk);
    chk("pre_disable_angle_pin", pwm_angle, 1);
    enable = 1'b0;
    @(negedge clk);
    chk("disable_speed_pin", pwm_speed, 0);
    chk("disable_angle_pin", pwm_angle, 0);
    wait_strobe(n);
    chk("disable_speed_safe", speed_applied, 0);
    chk("disable_angle_safe", angle_applied, PNEU);
    speed_control = 16'd12;
    enable = 1'b1;
    count_frame(hs, ha);
    chk("reenable_quiet_speed", hs, 0);
    chk("reenable_quiet_angle", ha, 0);
    chk("reenable_speed_1", speed_applied, 10);
    wait_strobe(n);
    chk("reenable_speed_2", speed_applied, 12);

    // Enable drops on the frame-start edge itself.
    repeat (F - 1) @(negedge clk);
    enable = 1'b0;
    wait_strobe(n);
    chk("edge_disable_latency", n, 1);
    chk("edge_disable_speed", speed_applied, 0);
    chk("edge_disable_angle", angle_applied, PNEU);
    enable = 1'b1;
    wait_strobe(n);
    chk("edge_reenable_speed", speed_applied, 10);
    wait_strobe(n);

    // Asynchronous reset in the middle of a pulse.
    repeat (10) @(negedge clk);
    chk("pre_reset_speed_pin", pwm_speed, 1);
    chk("pre_reset_angle_pin", pwm_angle, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset_speed_pin", pwm_speed, 0);
    chk("async_reset_angle_pin", pwm_angle, 0);
    chk("async_reset_speed_applied", speed_applied, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    wait_strobe(n);
    chk("post_reset_strobe_latency", n, 80);
    chk("post_reset_speed", speed_applied, 10);
    wait_strobe(n);
    chk("post_reset_speed_2", speed_applied, 12);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/servo_pwm_gen.md
# servo_pwm_gen

Converts the microsecond pulse-width commands `speed_control` (ESC) and `angle_control` (steering servo) into two standard 50 Hz RC PWM pins. The commands come from the vehicle control logic. It sits between the control logic and the FPGA output pads. It re-times commands to frame boundaries, clamps them to the safe servo range, and slew-limits throttle so the drive never sees step changes.

## Interface
- `CLK_HZ`, 50_000_000: system clock frequency.
- `TICK_DIV`, CLK_HZ/1_000_000: clocks per 1 µs tick.
- `FRAME_US`, 20000: PWM period in µs.
- `PW_MIN`, 1000: minimum legal pulse width in µs.
- `PW_MAX`, 2000: maximum legal pulse width in µs.
- `PW_NEUTRAL`, 1500: angle channel reset/disable width in µs.
- `SLEW_US`, 50: maximum speed-width change per frame in µs.

- `clk`  in  1  system clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `enable`  in  1  1 = drive pins; 0 = pins low, channels return to safe values.
- `speed_control`  in  16  requested ESC width in µs, unsigned; 0 = channel off.
- `angle_control`  in  16  requested servo width in µs, unsigned.
- `pwm_speed`  out  1  ESC pulse pin.
- `pwm_angle`  out  1  servo pulse pin.
- `frame_strobe`  out  1  one-cycle pulse at each frame start.
- `speed_applied`  out  16  width in µs used in the current frame.
- `angle_applied`  out  16  width in µs used in the current frame.
- `clamped`  out  1  1 if either command was clamped at the last frame start.

## Operation
- **Prescaler.** `tick_cnt` counts 0..TICK_DIV-1. It wraps and emits a 1 µs tick.
- **Frame counter.** `us_cnt` counts 0..FRAME_US-1 and advances on each tick.
- **Frame start.** A frame start is the tick on which `us_cnt` wraps to 0. At each frame start, in one cycle:
  - sample both commands;
  - clamp them;
  - update the applied registers;
  - pulse `frame_strobe`.
- **Clamp rule**, per command value c:
  - c = 0 on the speed channel → off;
  - c < PW_MIN → PW_MIN;
  - c > PW_MAX → PW_MAX.
  - `clamped` is set if any substitution occurred. An off request is not a clamp.
  - `angle_control` = 0 clamps to PW_MIN.
- **Speed slew**, with T = clamped target and A = current applied value:
  - T off → A = 0 immediately (the safety path is never slewed);
  - A = 0 and T ≠ 0 → A = PW_MIN;
  - otherwise A moves toward T by min(|T−A|, SLEW_US).
- **Angle channel.** Takes the clamped value directly, with no slew.
- **Pulse generation.**
  - A pin is high while `us_cnt` < applied width.
  - An applied width of 0 keeps the pin low for the whole frame.
- **Disable.**
  - `enable` = 0 forces both pins low on the next clock.
  - Counters keep running.
  - At the next frame start, speed_applied becomes 0 and angle_applied becomes PW_NEUTRAL.
  - After re-enable, output resumes at the next frame start, and the speed channel ramps up from PW_MIN.
- **Arithmetic.** All width arithmetic is 16-bit unsigned. The slew difference is computed from the comparison result, so it never underflows.

## Timing
- **Reset values.**
  - Pins low, `frame_strobe` 0, `clamped` 0.
  - `speed_applied` 0, `angle_applied` PW_NEUTRAL.
  - `tick_cnt` 0, `us_cnt` 0.
- **First frame.** The first frame start occurs FRAME_US·TICK_DIV clocks after reset release.
- **Command latency.** A command change is ignored mid-frame. It takes effect at the next frame start, so latency is at most one frame.
- **Pin timing.** Pins are registered.
  - The rising edge is 1 clock after `frame_strobe`.
  - High time is exactly width·TICK_DIV clocks.
  - Period is exactly FRAME_US·TICK_DIV clocks.
- **Simultaneous events.** `enable` falling on a frame-start cycle gives pins low that frame and safe values loaded.
- **Mid-operation reset.** Reset asserted mid-pulse drives pins low asynchronously.

## Structure
- **Package `servo_pkg`.** Holds `PW_MIN`, `PW_MAX`, `PW_NEUTRAL`, `FRAME_US`, the width type (16-bit), and a clamp function shared with the control logic.
- **Sub-module `pwm_channel`.** Contains the applied register, the optional slew stage (enabled by parameter), and the pin compare against `us_cnt`. It is instantiated twice: once for speed with slew on, once for angle with slew off.
- **Top level.** Owns the prescaler, frame counter and strobe.

## Test plan
- **Reset.** Reset, `enable`=1, angle=1500, speed=2000 → `speed_applied` sequence 1000, 1050, …, 2000 over frames 1–21. `pwm_angle` high 1500·50 clocks per 20000·50 clock period.
- **Clamping.** angle=2600 then angle=400 → applied 2000 then 1000; `clamped`=1 both frames. angle=1200 → `clamped`=0.
- **Safety path.** Speed at 2000 steady, command 0 → `speed_applied`=0 and `pwm_speed` low from the very next frame (no ramp).
- **Mid-frame change.** Change angle from 1500 to 1000 at `us_cnt`=700 → current pulse still 1500 µs wide; next frame 1000 µs.
- **Disable.** Deassert `enable` mid-pulse → both pins low next clock. Next frame: `speed_applied`=0, `angle_applied`=1500. Re-enable with speed=1200 → 1000, 1050, …, 1200.
- **Async reset.** Assert `rst_n`=0 at `us_cnt`=500 → pins low without a clock edge. After release, the first `frame_strobe` comes exactly 1,000,000 clocks later.
